// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encoding, default bit period and a
// helper that sizes counters so they never need modular wrap.
package uart_defs;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_START_ENC = 2'd1;
  localparam logic [1:0] ST_DATA_ENC  = 2'd2;
  localparam logic [1:0] ST_STOP_ENC  = 2'd3;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_START = ST_START_ENC,
    ST_DATA  = ST_DATA_ENC,
    ST_STOP  = ST_STOP_ENC
  } state_t;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Upstream FIFO read port plus serial-side outputs of the transmitter.
//
// Handshake: i_fifo_empty=0 is the "valid" from the FIFO and
// o_fifo_rd_stb is the "ready"/pop. A word moves on every rising edge
// where o_fifo_rd_stb=1; the transmitter only raises it while
// i_fifo_empty=0, so a pop is never issued against an empty FIFO.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  i_fifo_empty;
  logic                  o_fifo_rd_stb;
  logic                  o_tx;
  logic                  o_busy;
  logic                  o_done;

  modport slave (
    input  i_fifo_data,
    input  i_fifo_empty,
    output o_fifo_rd_stb,
    output o_tx,
    output o_busy,
    output o_done
  );

  modport master (
    output i_fifo_data,
    output i_fifo_empty,
    input  o_fifo_rd_stb,
    input  o_tx,
    input  o_busy,
    input  o_done
  );
endinterface

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and flags the
// last cycle of each bit. Held at zero whenever the frame is not running.
module uart_baud_gen
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  output logic o_tick
);

  localparam int              CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Counter restarts by explicit clear at the end of every bit.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = i_run && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed from an external show-ahead FIFO. Frame is
// start(0), DATA_WIDTH bits LSB first, stop(1). The serial line is
// registered from the next state so the start bit appears one cycle
// after the pop.
module uart_tx
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  uart_tx_if.slave      bus,
  output state_t        o_state
);

  localparam int               BIT_W    = cnt_width(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic                  tx_q, tx_n;
  logic                  rd_stb;
  logic                  done;
  logic                  tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_run  (state != ST_IDLE),
    .o_tick (tick)
  );

  // State, shift register, bit counter and line register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_n;
      tx_q    <= tx_n;
    end
  end

  // Next-state, pop strobe, done pulse and next line value.
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    tx_n    = 1'b1;
    rd_stb  = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        bit_n = '0;
        if (!bus.i_fifo_empty) begin
          rd_stb  = 1'b1;
          shift_n = bus.i_fifo_data;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_n = shift >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_n   = '0;
            state_n = ST_STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Reset wins the same cycle: no pop, no done.
    if (i_reset) begin
      rd_stb = 1'b0;
      done   = 1'b0;
    end

    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  assign bus.o_fifo_rd_stb = rd_stb;
  assign bus.o_tx          = tx_q;
  assign bus.o_busy        = (state != ST_IDLE);
  assign bus.o_done        = done;
  assign o_state           = state;

endmodule
